// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
//   arb_state_t : access sequencer states (IDLE -> ISSUE -> WAIT -> RESP)
//   arb_owner_t : which requester currently owns the memory port
//   WMASK_FULL  : byte-enable pattern for full-word writes
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2,
        OWN_DBG  = 2'd3
    } arb_owner_t;

    localparam logic [3:0] WMASK_FULL = 4'b1111;

endpackage

// File: rtl/mem_arb_priority.sv
// Winner selection for the memory port arbiter.
// Fixed order dbg > ls > if, except that a fetch which has lost STARVE_LIMIT
// arbitrations in a row is promoted above ls (never above dbg).
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   arb_en            : arbiter is in IDLE; only then does a grant take effect
//   if_req/ls_req/dbg_req : pending requests
//   grant             : combinational winner (OWN_NONE when nothing pending)
module mem_arb_priority
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       arb_en,
    input  logic       if_req,
    input  logic       ls_req,
    input  logic       dbg_req,
    output arb_owner_t grant
);

    logic [3:0] starve_cnt_reg;
    logic [3:0] starve_cnt_next;
    logic       starved;

    // Counter saturates at the limit, so ">=" and "==" agree; ">=" keeps the
    // promotion sticky even if dbg keeps winning meanwhile.
    assign starved = (starve_cnt_reg >= 4'(STARVE_LIMIT));

    always_comb begin
        grant = OWN_NONE;
        if (dbg_req) begin
            grant = OWN_DBG;
        end else if (if_req && starved) begin
            grant = OWN_IF;
        end else if (ls_req) begin
            grant = OWN_LS;
        end else if (if_req) begin
            grant = OWN_IF;
        end
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!if_req) begin
            starve_cnt_next = 4'd0;
        end else if (arb_en) begin
            // if_req is high here, so some requester is granted this cycle.
            if (grant == OWN_IF) begin
                starve_cnt_next = 4'd0;
            end else if (!starved) begin
                starve_cnt_next = starve_cnt_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_reg <= 4'd0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port unified memory between instruction fetch (if_*),
// load/store (ls_*) and the debug/loader port (dbg_*). Every access runs
// through IDLE -> ISSUE -> WAIT -> RESP; ack arrives MEM_LATENCY cycles after
// the mem_en strobe. cpu_stall is raised while a core request is unserved.
// Ports:
//   clock, reset            : rising-edge clock, asynchronous active-high reset
//   if_req/if_addr -> if_ack/if_rdata            : fetch port (read only)
//   ls_req/ls_we/ls_wmask/ls_addr/ls_wdata -> ls_ack/ls_rdata : load/store
//   dbg_req/dbg_we/dbg_addr/dbg_wdata -> dbg_ack/dbg_rdata   : debug, full word
//   mem_en/mem_we/mem_wmask/mem_addr/mem_wdata, mem_rdata    : memory side
//   cpu_stall, busy         : core freeze request, sequencer not idle
// Optional: define MEM_ARB_PERF_CNT_EN to add saturating counters
//   perf_if_grants, perf_ls_grants, perf_conflict_cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [3:0]            ls_wmask,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_ack,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_wmask,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cpu_stall,
    output logic                  busy
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_if_grants,
    output logic [31:0]           perf_ls_grants,
    output logic [31:0]           perf_conflict_cycles
`endif
);

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY - 1);

    arb_state_t            state_reg, state_next;
    arb_owner_t            owner_reg;
    arb_owner_t            grant;
    logic [2:0]            lat_cnt_reg;
    logic                  we_reg;
    logic [3:0]            wmask_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;

    logic                  sel_we;
    logic [3:0]            sel_wmask;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  in_issue;
    logic                  in_resp;

    mem_arb_priority #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clock  (clock),
        .reset  (reset),
        .arb_en (state_reg == IDLE),
        .if_req (if_req),
        .ls_req (ls_req),
        .dbg_req(dbg_req),
        .grant  (grant)
    );

    // Payload of whichever requester wins this cycle.
    always_comb begin
        sel_we    = 1'b0;
        sel_wmask = 4'b0000;
        sel_addr  = if_addr;
        sel_wdata = '0;
        case (grant)
            OWN_DBG: begin
                sel_we    = dbg_we;
                sel_wmask = WMASK_FULL;
                sel_addr  = dbg_addr;
                sel_wdata = dbg_wdata;
            end
            OWN_LS: begin
                sel_we    = ls_we;
                sel_wmask = ls_wmask;
                sel_addr  = ls_addr;
                sel_wdata = ls_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant != OWN_NONE) state_next = ISSUE;
            ISSUE:   state_next = (MEM_LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (lat_cnt_reg <= 3'd1) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            owner_reg   <= OWN_NONE;
            lat_cnt_reg <= 3'd0;
            we_reg      <= 1'b0;
            wmask_reg   <= 4'b0000;
            addr_reg    <= '0;
            wdata_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (grant != OWN_NONE) begin
                        owner_reg <= grant;
                        we_reg    <= sel_we;
                        wmask_reg <= sel_wmask;
                        addr_reg  <= sel_addr;
                        wdata_reg <= sel_wdata;
                    end
                end
                ISSUE:   lat_cnt_reg <= LAT_LOAD;
                WAIT:    lat_cnt_reg <= lat_cnt_reg - 3'd1;
                RESP:    owner_reg <= OWN_NONE;
                default: ;
            endcase
        end
    end

    assign in_issue = (state_reg == ISSUE);
    assign in_resp  = (state_reg == RESP);

    // Memory command is only presented during ISSUE; zero otherwise.
    assign mem_en    = in_issue;
    assign mem_we    = in_issue & we_reg;
    assign mem_wmask = in_issue ? wmask_reg : 4'b0000;
    assign mem_addr  = in_issue ? addr_reg : '0;
    assign mem_wdata = in_issue ? wdata_reg : '0;

    // Response steering: read data is forwarded only to the owner, only in RESP.
    assign if_ack    = in_resp && (owner_reg == OWN_IF);
    assign ls_ack    = in_resp && (owner_reg == OWN_LS);
    assign dbg_ack   = in_resp && (owner_reg == OWN_DBG);
    assign if_rdata  = if_ack  ? mem_rdata : '0;
    assign ls_rdata  = ls_ack  ? mem_rdata : '0;
    assign dbg_rdata = dbg_ack ? mem_rdata : '0;

    assign cpu_stall = (if_req & ~if_ack) | (ls_req & ~ls_ack);
    assign busy      = (state_reg != IDLE);

`ifdef MEM_ARB_PERF_CNT_EN
    logic conflict;
    logic grant_if_now;
    logic grant_ls_now;

    assign conflict     = (if_req & ls_req) | (if_req & dbg_req) | (ls_req & dbg_req);
    assign grant_if_now = (state_reg == IDLE) && (grant == OWN_IF);
    assign grant_ls_now = (state_reg == IDLE) && (grant == OWN_LS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_if_grants       <= 32'd0;
            perf_ls_grants       <= 32'd0;
            perf_conflict_cycles <= 32'd0;
        end else begin
            if (grant_if_now && (perf_if_grants != 32'hFFFF_FFFF)) begin
                perf_if_grants <= perf_if_grants + 32'd1;
            end
            if (grant_ls_now && (perf_ls_grants != 32'hFFFF_FFFF)) begin
                perf_ls_grants <= perf_ls_grants + 32'd1;
            end
            if (conflict && (perf_conflict_cycles != 32'hFFFF_FFFF)) begin
                perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Instance A runs MEM_LATENCY=1,
// instance B runs MEM_LATENCY=3; both STARVE_LIMIT=4. Stimulus pushes the
// expected memory commands and acks; monitors pop and compare on mem_en/ack.
// With MEM_ARB_PERF_CNT_EN defined the perf counters are also checked.
module tb_mem_port_arbiter;

    typedef struct {
        int          port;    // 0 if, 1 ls, 2 dbg
        logic        has_rd;
        logic [31:0] rdata;
        int          cyc;     // -1: any cycle
    } ack_t;

    typedef struct {
        logic        we;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } cmd_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ack_t a_q[$];
    ack_t b_q[$];
    cmd_t a_cq[$];
    cmd_t b_cq[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- instance A signals ----------------
    logic        if_req = 0, ls_req = 0, ls_we = 0, dbg_req = 0, dbg_we = 0;
    logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
    logic [3:0]  ls_wmask = 0;
    logic        if_ack, ls_ack, dbg_ack, mem_en, mem_we, cpu_stall, busy;
    logic [31:0] if_rdata, ls_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    // ---------------- instance B signals ----------------
    logic        b_if_req = 0, b_ls_req = 0, b_ls_we = 0, b_dbg_req = 0, b_dbg_we = 0;
    logic [31:0] b_if_addr = 0, b_ls_addr = 0, b_ls_wdata = 0, b_dbg_addr = 0, b_dbg_wdata = 0;
    logic [3:0]  b_ls_wmask = 0;
    logic        b_if_ack, b_ls_ack, b_dbg_ack, b_mem_en, b_mem_we, b_cpu_stall, b_busy;
    logic [31:0] b_if_rdata, b_ls_rdata, b_dbg_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_wmask;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] a_perf_if, a_perf_ls, a_perf_cf, b_perf_if, b_perf_ls, b_perf_cf;
`endif

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_wmask(ls_wmask), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_stall(cpu_stall), .busy(busy)
`ifdef MEM_ARB_PERF_CNT_EN
        , .perf_if_grants(a_perf_if), .perf_ls_grants(a_perf_ls), .perf_conflict_cycles(a_perf_cf)
`endif
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut_b (
        .clock(clock), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_wmask(b_ls_wmask), .ls_addr(b_ls_addr),
        .ls_wdata(b_ls_wdata), .ls_ack(b_ls_ack), .ls_rdata(b_ls_rdata),
        .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
        .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_wmask(b_mem_wmask), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .cpu_stall(b_cpu_stall), .busy(b_busy)
`ifdef MEM_ARB_PERF_CNT_EN
        , .perf_if_grants(b_perf_if), .perf_ls_grants(b_perf_ls), .perf_conflict_cycles(b_perf_cf)
`endif
    );

    // ---------------- memory models ----------------
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] rd_a = 0, b_p1 = 0, b_p2 = 0, b_p3 = 0;

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_wmask[i]) mem_a[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                rd_a <= mem_a[mem_addr[9:2]];
            end
        end
    end
    assign mem_rdata = rd_a;

    always @(posedge clock) begin
        if (b_mem_en && b_mem_we) begin
            for (int i = 0; i < 4; i++)
                if (b_mem_wmask[i]) mem_b[b_mem_addr[9:2]][8*i +: 8] <= b_mem_wdata[8*i +: 8];
        end
        b_p1 <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr[9:2]] : 32'h0;
        b_p2 <= b_p1;
        b_p3 <= b_p2;
    end
    assign b_mem_rdata = b_p3;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ack_event(input string tag, input int n, input int port,
                             input logic [31:0] rd, input bit have, input ack_t e);
        if (n > 1) chk({tag, "_multi_ack"}, n, 1);
        if (!have) begin
            chk({tag, "_unexpected_ack"}, n, 0);
        end else begin
            chk({tag, "_ack_port"}, port, e.port);
            if (e.has_rd) chk({tag, "_rdata"}, rd, e.rdata);
            if (e.cyc >= 0) chk({tag, "_ack_cycle"}, cyc, e.cyc);
        end
        $display("%s ack port=%0d rdata=%h cycle=%0d", tag, port, rd, cyc);
    endtask

    task automatic cmd_event(input string tag, input logic we, input logic [3:0] mask,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input bit have, input cmd_t c);
        if (!have) begin
            chk({tag, "_unexpected_mem_en"}, 1'b1, 1'b0 ^ we ^ we);
        end else begin
            chk({tag, "_mem_we"}, we, c.we);
            chk({tag, "_mem_addr"}, addr, c.addr);
            if (c.we) begin
                chk({tag, "_mem_wmask"}, mask, c.mask);
                chk({tag, "_mem_wdata"}, wdata, c.wdata);
            end
            if (c.cyc >= 0) chk({tag, "_mem_en_cycle"}, cyc, c.cyc);
        end
        $display("%s mem we=%0d mask=%b addr=%h wdata=%h cycle=%0d", tag, we, mask, addr, wdata, cyc);
    endtask

    always @(negedge clock) begin : mon_a
        int   n;
        bit   have;
        ack_t e;
        cmd_t c;
        n = int'(if_ack) + int'(ls_ack) + int'(dbg_ack);
        if (!reset && n != 0) begin
            have = (a_q.size() != 0);
            if (have) e = a_q.pop_front();
            else e = '{port: 0, has_rd: 1'b0, rdata: 32'h0, cyc: -1};
            ack_event("A", n, if_ack ? 0 : (ls_ack ? 1 : 2),
                      if_ack ? if_rdata : (ls_ack ? ls_rdata : dbg_rdata), have, e);
        end
        if (!reset && mem_en) begin
            have = (a_cq.size() != 0);
            if (have) c = a_cq.pop_front();
            else c = '{we: 1'b0, mask: 4'h0, addr: 32'h0, wdata: 32'h0, cyc: -1};
            cmd_event("A", mem_we, mem_wmask, mem_addr, mem_wdata, have, c);
        end
    end

    always @(negedge clock) begin : mon_b
        int   n;
        bit   have;
        ack_t e;
        cmd_t c;
        n = int'(b_if_ack) + int'(b_ls_ack) + int'(b_dbg_ack);
        if (!reset && n != 0) begin
            have = (b_q.size() != 0);
            if (have) e = b_q.pop_front();
            else e = '{port: 0, has_rd: 1'b0, rdata: 32'h0, cyc: -1};
            ack_event("B", n, b_if_ack ? 0 : (b_ls_ack ? 1 : 2),
                      b_if_ack ? b_if_rdata : (b_ls_ack ? b_ls_rdata : b_dbg_rdata), have, e);
        end
        if (!reset && b_mem_en) begin
            have = (b_cq.size() != 0);
            if (have) c = b_cq.pop_front();
            else c = '{we: 1'b0, mask: 4'h0, addr: 32'h0, wdata: 32'h0, cyc: -1};
            cmd_event("B", b_mem_we, b_mem_wmask, b_mem_addr, b_mem_wdata, have, c);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic a_wait(input int which);
        int   k;
        logic a;
        a = 1'b0;
        for (k = 0; k < 100; k++) begin
            @(negedge clock);
            a = (which == 0) ? if_ack : ((which == 1) ? ls_ack : dbg_ack);
            if (a) break;
        end
        if (k == 100) chk("a_ack_timeout", a, 1'b1);
    endtask

    task automatic b_wait(input int which);
        int   k;
        logic a;
        a = 1'b0;
        for (k = 0; k < 100; k++) begin
            @(negedge clock);
            a = (which == 0) ? b_if_ack : ((which == 1) ? b_ls_ack : b_dbg_ack);
            if (a) break;
        end
        if (k == 100) chk("b_ack_timeout", a, 1'b1);
    endtask

    task automatic a_dbg(input logic we, input logic [31:0] a, input logic [31:0] d);
        int t;
        step();
        t = cyc;
        a_cq.push_back('{we: we, mask: 4'hF, addr: a, wdata: d, cyc: t + 1});
        a_q.push_back('{port: 2, has_rd: !we, rdata: d, cyc: t + 2});
        dbg_we = we; dbg_addr = a; dbg_wdata = we ? d : 32'h0; dbg_req = 1;
        a_wait(2);
        dbg_req = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int t, bc, seen;
`ifdef MEM_ARB_PERF_CNT_EN
        logic [31:0] p_if0, p_ls0, p_cf0;
`endif
        repeat (3) @(posedge clock);
        #1;
        chk("a_reset_ctrl", {busy, mem_en, mem_we, if_ack, ls_ack, dbg_ack, cpu_stall}, 0);
        chk("a_reset_data", if_rdata | ls_rdata | dbg_rdata | mem_addr | mem_wdata, 0);
        chk("b_reset_ctrl", {b_busy, b_mem_en, b_mem_we, b_if_ack, b_ls_ack, b_dbg_ack}, 0);
        reset = 0;
        step();
        chk("a_idle_stall", cpu_stall, 1'b0);

        // Preload program/data words through the debug port.
        a_dbg(1'b1, 32'h10, 32'h0050_0093);
        a_dbg(1'b1, 32'h20, 32'h00A0_0113);
        a_dbg(1'b1, 32'h40, 32'h1122_3344);

        // Fetch from idle: mem_en one cycle later, ack the cycle after.
        step();
        t = cyc;
        a_cq.push_back('{we: 1'b0, mask: 4'h0, addr: 32'h10, wdata: 32'h0, cyc: t + 1});
        a_q.push_back('{port: 0, has_rd: 1'b1, rdata: 32'h0050_0093, cyc: t + 2});
        if_addr = 32'h10; if_req = 1;
        a_wait(0);
        if_req = 0;

        // All three at once: dbg, then masked ls store, then fetch.
        step();
        t = cyc;
`ifdef MEM_ARB_PERF_CNT_EN
        p_if0 = a_perf_if; p_ls0 = a_perf_ls; p_cf0 = a_perf_cf;
`endif
        a_cq.push_back('{we: 1'b0, mask: 4'h0, addr: 32'h10, wdata: 32'h0, cyc: t + 1});
        a_q.push_back('{port: 2, has_rd: 1'b1, rdata: 32'h0050_0093, cyc: t + 2});
        a_cq.push_back('{we: 1'b1, mask: 4'b0011, addr: 32'h40, wdata: 32'hAABB_CCDD, cyc: t + 4});
        a_q.push_back('{port: 1, has_rd: 1'b0, rdata: 32'h0, cyc: t + 5});
        a_cq.push_back('{we: 1'b0, mask: 4'h0, addr: 32'h10, wdata: 32'h0, cyc: t + 7});
        a_q.push_back('{port: 0, has_rd: 1'b1, rdata: 32'h0050_0093, cyc: t + 8});
        dbg_we = 0; dbg_addr = 32'h10; dbg_req = 1;
        ls_we = 1; ls_wmask = 4'b0011; ls_addr = 32'h40; ls_wdata = 32'hAABB_CCDD; ls_req = 1;
        if_addr = 32'h10; if_req = 1;
        fork
            begin a_wait(2); dbg_req = 0; end
            begin a_wait(1); ls_req = 0; end
            begin a_wait(0); if_req = 0; end
            begin
                for (int k = 0; k < 100; k++) begin
                    @(negedge clock);
                    if (if_ack) begin
                        chk("stall_at_if_ack", cpu_stall, 1'b0);
                        break;
                    end
                    chk("stall_pending", cpu_stall, 1'b1);
                end
            end
        join
`ifdef MEM_ARB_PERF_CNT_EN
        chk("perf_if_grants", a_perf_if - p_if0, 32'd1);
        chk("perf_ls_grants", a_perf_ls - p_ls0, 32'd1);
        chk("perf_conflict_cycles", a_perf_cf - p_cf0, 32'd5);
`endif
        // Only the low two bytes of the store may have landed.
        a_dbg(1'b0, 32'h40, 32'h1122_CCDD);

        // Starvation: ls held continuously, fetch wins the fifth grant.
        step();
        t = cyc;
        for (int k = 0; k < 4; k++) begin
            a_cq.push_back('{we: 1'b0, mask: 4'h0, addr: 32'h10, wdata: 32'h0, cyc: t + 3*k + 1});
            a_q.push_back('{port: 1, has_rd: 1'b1, rdata: 32'h0050_0093, cyc: t + 3*k + 2});
        end
        a_cq.push_back('{we: 1'b0, mask: 4'h0, addr: 32'h20, wdata: 32'h0, cyc: t + 13});
        a_q.push_back('{port: 0, has_rd: 1'b1, rdata: 32'h00A0_0113, cyc: t + 14});
        a_cq.push_back('{we: 1'b0, mask: 4'h0, addr: 32'h10, wdata: 32'h0, cyc: t + 16});
        a_q.push_back('{port: 1, has_rd: 1'b1, rdata: 32'h0050_0093, cyc: t + 17});
        ls_we = 0; ls_addr = 32'h10; ls_req = 1;
        if_addr = 32'h20; if_req = 1;
        fork
            begin repeat (5) a_wait(1); ls_req = 0; end
            begin a_wait(0); if_req = 0; end
            begin
                do @(negedge clock); while (cyc < t + 10);
                chk("starve_cnt_at_limit", 32'(dut_a.u_prio.starve_cnt_reg), 32'd4);
                do @(negedge clock); while (cyc < t + 13);
                chk("starve_cnt_cleared", 32'(dut_a.u_prio.starve_cnt_reg), 32'd0);
            end
        join

        // Instance B (latency 3): debug write then read of 0x8.
        step();
        t = cyc;
        b_cq.push_back('{we: 1'b1, mask: 4'hF, addr: 32'h8, wdata: 32'hCAFE_F00D, cyc: t + 1});
        b_q.push_back('{port: 2, has_rd: 1'b0, rdata: 32'h0, cyc: t + 4});
        b_dbg_we = 1; b_dbg_addr = 32'h8; b_dbg_wdata = 32'hCAFE_F00D; b_dbg_req = 1;
        b_wait(2);
        b_dbg_req = 0;

        step();
        t = cyc;
        b_cq.push_back('{we: 1'b0, mask: 4'h0, addr: 32'h8, wdata: 32'h0, cyc: t + 1});
        b_q.push_back('{port: 2, has_rd: 1'b1, rdata: 32'hCAFE_F00D, cyc: t + 4});
        b_dbg_we = 0; b_dbg_req = 1;
        bc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            bc += int'(b_busy);
            if (b_dbg_ack) break;
        end
        b_dbg_req = 0;
        chk("b_busy_cycles", bc, 4);
        step();
        chk("b_busy_after", b_busy, 1'b0);

        // Reset in WAIT of a B load: everything drops, no ack follows.
        t = cyc;
        b_cq.push_back('{we: 1'b0, mask: 4'h0, addr: 32'h8, wdata: 32'h0, cyc: t + 1});
        b_ls_we = 0; b_ls_addr = 32'h8; b_ls_req = 1;
        step();
        step();
        chk("b_in_wait", {b_busy, b_mem_en}, 2'b10);
        reset = 1;
        b_ls_req = 0;
        #1;
        chk("b_rst_ctrl", {b_busy, b_mem_en, b_mem_we, b_if_ack, b_ls_ack, b_dbg_ack, b_cpu_stall}, 0);
        chk("b_rst_data", b_if_rdata | b_ls_rdata | b_dbg_rdata | b_mem_addr | b_mem_wdata | 32'(b_mem_wmask), 0);
        step();
        step();
        reset = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            seen |= int'(b_ls_ack);
        end
        chk("b_no_ls_ack", seen, 0);

        step();
        t = cyc;
        b_cq.push_back('{we: 1'b0, mask: 4'h0, addr: 32'h8, wdata: 32'h0, cyc: t + 1});
        b_q.push_back('{port: 0, has_rd: 1'b1, rdata: 32'hCAFE_F00D, cyc: t + 4});
        b_if_addr = 32'h8; b_if_req = 1;
        b_wait(0);
        b_if_req = 0;

        repeat (4) step();
        chk("a_queues_drained", a_q.size() + a_cq.size(), 0);
        chk("b_queues_drained", b_q.size() + b_cq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
